// File: rtl/cla_acc_seq.sv
// Sequential multi-operand accumulator wrapped around a 32-bit carry-lookahead adder.
// One operand per cycle is folded into acc; the result is offered over valid/ready.
module cla_acc_seq #(
  parameter int CNT_W   = 8,
  parameter int CARRY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   len,
  input  logic [31:0]        init,
  input  logic               in_valid,
  input  logic [31:0]        in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_sum,
  output logic [CARRY_W-1:0] out_carries,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t             state, state_nxt;
  logic [31:0]        acc;
  logic [CARRY_W-1:0] carries;
  logic [CNT_W-1:0]   remaining;
  logic [32:0]        cla_res;

  // 4-bit group lookahead: group carries are resolved first, then bit carries inside each group.
  function automatic logic [32:0] cla_32(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin);
    logic [31:0] g, p;
    logic [32:0] c;
    logic [7:0]  gg, gp;
    logic [8:0]  gc;
    g     = a & b;
    p     = a ^ b;
    gc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      gg[k] = 1'b0;
      gp[k] = 1'b1;
      for (int j = 0; j < 4; j++) begin
        gg[k] = g[4*k+j] | (p[4*k+j] & gg[k]);
        gp[k] = gp[k] & p[4*k+j];
      end
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    c = '0;
    for (int k = 0; k < 8; k++) begin
      c[4*k] = gc[k];
      for (int j = 0; j < 3; j++) begin
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      end
    end
    c[32] = gc[8];
    return {c[32], p ^ c[31:0]};
  endfunction

  function automatic logic [CARRY_W-1:0] sat_inc(input logic [CARRY_W-1:0] cnt,
                                                 input logic inc);
    if (inc && !(&cnt)) return cnt + CARRY_W'(1);
    return cnt;
  endfunction

  assign cla_res = cla_32(acc, in_data, 1'b0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (len != '0) ? ACC : DONE;
      ACC:  if (in_valid && remaining == CNT_W'(1)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Accumulator stage: acc only moves on start in IDLE or an operand handshake in ACC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      carries   <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc       <= init;
          carries   <= '0;
          remaining <= len;
        end
        ACC: if (in_valid) begin
          acc       <= cla_res[31:0];
          carries   <= sat_inc(carries, cla_res[32]);
          remaining <= remaining - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == ACC);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign out_sum     = acc;
  assign out_carries = carries;

endmodule

// File: tb/tb_cla_acc_seq.sv
// Randomized bench for cla_acc_seq; expected results come from plain 64-bit arithmetic.
module tb_cla_acc_seq;
  localparam int CNT_W   = 8;
  localparam int CARRY_W = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [CNT_W-1:0]   len;
  logic [31:0]        init;
  logic               in_valid;
  logic [31:0]        in_data;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_sum;
  logic [CARRY_W-1:0] out_carries;
  logic               busy;

  int total = 0;
  int bad   = 0;
  logic [31:0] ops[$];

  cla_acc_seq #(.CNT_W(CNT_W), .CARRY_W(CARRY_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .init(init),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_carries(out_carries), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: wide addition, count every carry out of bit 31, clamp at counter max.
  task automatic model(input logic [31:0] ini, output logic [31:0] s,
                       output logic [CARRY_W-1:0] c);
    logic [63:0] t;
    int n, cap;
    s = ini;
    n = 0;
    foreach (ops[i]) begin
      t = {32'b0, s} + {32'b0, ops[i]};
      if (t > 64'hFFFF_FFFF) n++;
      s = t[31:0];
    end
    cap = (1 << CARRY_W) - 1;
    c = CARRY_W'((n > cap) ? cap : n);
  endtask

  // mode 0: back-to-back, 1: random gaps plus stray start, 2: valid pattern 1,0,0,1,1,0,1
  task automatic run_job(input string nm, input logic [31:0] ini, input int mode, input int hold);
    int n, idx, cyc;
    logic hs, ok_ready, early, stable;
    logic [6:0] pat;
    logic [31:0] es;
    logic [CARRY_W-1:0] ec;
    n = ops.size();
    pat = 7'b1011001;
    model(ini, es, ec);
    start = 1'b1; len = CNT_W'(n); init = ini;
    @(posedge clk); #1;
    start = 1'b0;
    idx = 0; cyc = 0; ok_ready = 1'b1; early = 1'b0;
    while (idx < n && cyc < 200) begin
      case (mode)
        1:       in_valid = 1'($urandom % 2);
        2:       in_valid = (cyc < 7) ? pat[cyc] : 1'b1;
        default: in_valid = 1'b1;
      endcase
      if (mode == 1) begin
        start = 1'($urandom % 2); len = CNT_W'($urandom); init = $urandom;
      end
      in_data = ops[idx];
      if (in_ready !== 1'b1) ok_ready = 1'b0;
      if (out_valid !== 1'b0) early = 1'b1;
      hs = in_valid;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0;
    chk({nm, "_handshakes"}, 64'(idx), 64'(n));
    chk({nm, "_ready_in_acc"}, 64'(ok_ready), 64'd1);
    chk({nm, "_no_early_valid"}, 64'(early), 64'd0);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_in_ready_done"}, 64'(in_ready), 64'd0);
    chk({nm, "_sum"}, 64'(out_sum), 64'(es));
    chk({nm, "_carries"}, 64'(out_carries), 64'(ec));
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      start = 1'b1; init = ~ini; len = '0;
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_sum !== es || out_carries !== ec) stable = 1'b0;
    end
    start = 1'b0;
    if (hold > 0) chk({nm, "_hold_stable"}, 64'(stable), 64'd1);
    out_ready = 1'b1; start = 1'b1; init = ~ini; len = '0;
    @(posedge clk); #1;
    out_ready = 1'b0; start = 1'b0;
    chk({nm, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({nm, "_idle"}, 64'(busy), 64'd0);
    chk({nm, "_sum_kept"}, 64'(out_sum), 64'(es));
    @(posedge clk); #1;
    chk({nm, "_start_on_ack_ignored"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; init = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {out_sum, 16'(out_carries), 5'b0, in_ready, out_valid, busy}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    ops = '{32'd1, 32'd2, 32'd3};
    run_job("basic", 32'd0, 0, 0);
    ops = '{32'd1, 32'hFFFF_FFFF};
    run_job("wrap", 32'hFFFF_FFFF, 0, 0);
    ops = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    run_job("sat", 32'hFFFF_FFFF, 0, 0);
    ops = {};
    run_job("zero", 32'h1234, 0, 5);
    ops = '{32'd10, 32'd20, 32'd30, 32'd40};
    run_job("gap", 32'd0, 2, 0);

    for (int r = 0; r < 20; r++) begin
      ops = {};
      for (int i = 0; i < int'($urandom_range(0, 10)); i++)
        ops.push_back(($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom);
      run_job("rnd", $urandom, 1, int'($urandom % 3));
    end

    // Abort a job after two operands with an asynchronous reset.
    start = 1'b1; len = CNT_W'(4); init = 32'd100;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 32'd9;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_outs", {out_sum, 16'(out_carries), 5'b0, in_ready, out_valid, busy}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    ops = '{32'd7};
    run_job("after_rst", 32'd5, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
